// File: rtl/mmm_pkg.sv
// Shared types, default dimensions and width helpers for the matrix-multiply sequencer.
package mmm_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DRAIN   = 2'd2,
    DONE    = 2'd3
  } state_e;

  localparam int DEF_M    = 7;
  localparam int DEF_N    = 9;
  localparam int DEF_MAXK = 8;

  // Bits needed to index n distinct values, never less than one.
  function automatic int clog2w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mmm_if.sv
// Bundle of the sequencer's data-path and memory-side signals.
// master = the sequencer, slave = input_mems / mac_pipe / fifo_out side.
interface mmm_if import mmm_pkg::*; #(
  parameter int M     = DEF_M,
  parameter int N     = DEF_N,
  parameter int MAXK  = DEF_MAXK,
  parameter int DEPTH = N
) ();

  localparam int K_BITS = clog2w(MAXK + 1);
  localparam int AW     = clog2w(M * MAXK);
  localparam int BW     = clog2w(MAXK * N);
  localparam int CW     = clog2w(DEPTH + 1);

  logic              matrices_loaded;
  logic [K_BITS-1:0] K;
  logic              compute_finished;
  logic [AW-1:0]     A_read_addr;
  logic [BW-1:0]     B_read_addr;
  logic              clear_acc;
  logic              valid_input;
  logic              fifo_wr_en;
  logic [CW-1:0]     fifo_capacity;

  modport master (
    input  matrices_loaded, K, fifo_capacity,
    output compute_finished, A_read_addr, B_read_addr,
           clear_acc, valid_input, fifo_wr_en
  );

  modport slave (
    output matrices_loaded, K, fifo_capacity,
    input  compute_finished, A_read_addr, B_read_addr,
           clear_acc, valid_input, fifo_wr_en
  );

endinterface

// File: rtl/mmm_delay_line.sv
// Fixed-latency shift register aligning control bits with memory / MAC latency.
// busy_o is high while any stage still holds a non-zero bit.
module mmm_delay_line #(
  parameter int LAT   = 1,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o,
  output logic             busy_o
);

  if (LAT == 0) begin : g_pass
    assign q_o    = d_i;
    assign busy_o = 1'b0;
  end else begin : g_shift
    logic [WIDTH-1:0] stage_q [LAT];
    logic             busy_s;

    // Advance every stage by one clock; reset empties the line.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int s = 0; s < LAT; s++) stage_q[s] <= '0;
      end else begin
        stage_q[0] <= d_i;
        for (int s = 1; s < LAT; s++) stage_q[s] <= stage_q[s-1];
      end
    end

    // Line is busy while any stage carries a set bit.
    always_comb begin
      busy_s = 1'b0;
      for (int s = 0; s < LAT; s++) busy_s = busy_s | (|stage_q[s]);
    end

    assign q_o    = stage_q[LAT-1];
    assign busy_o = busy_s;
  end

endmodule

// File: rtl/mmm_ctrl.sv
// Sequencer for the matrix-multiply datapath: walks C[i][j] over k, issues
// A/B reads, aligns MAC controls and gates fifo_out writes with a credit check.
// DEPTH/M/N/MAXK must match the parameters of the connected mmm_if instance.
module mmm_ctrl import mmm_pkg::*; #(
  parameter int M       = DEF_M,
  parameter int N       = DEF_N,
  parameter int MAXK    = DEF_MAXK,
  parameter int DEPTH   = N,
  parameter int RD_LAT  = 1,
  parameter int MAC_LAT = 2
) (
  input  logic  clk,
  input  logic  reset,
  mmm_if.master bus
);

  localparam int K_BITS = clog2w(MAXK + 1);
  localparam int AW     = clog2w(M * MAXK);
  localparam int BW     = clog2w(MAXK * N);
  localparam int CW     = clog2w(DEPTH + 1);
  localparam int IW     = clog2w(M);
  localparam int JW     = clog2w(N);

  state_e            state_q, state_d;
  logic [K_BITS-1:0] k_lim_q, k_lim_d, k_q, k_d;
  logic [IW-1:0]     i_q, i_d;
  logic [JW-1:0]     j_q, j_d;
  logic [AW-1:0]     a_base_q, a_base_d, a_addr_q, a_addr_d;
  logic [BW-1:0]     b_ptr_q, b_ptr_d;
  logic [CW-1:0]     in_flight_q, in_flight_d;
  logic              fin_q;

  logic issue_s, first_s, last_s;
  logic vld_s, clr_s, wr_s, busy_rd_s, busy_wr_s;

  assign first_s = (k_q == '0);
  assign last_s  = (k_q == (k_lim_q - K_BITS'(1)));

  // Next-state, counter stepping and credit-gated issue decision.
  always_comb begin
    state_d     = state_q;
    k_lim_d     = k_lim_q;
    k_d         = k_q;
    i_d         = i_q;
    j_d         = j_q;
    a_base_d    = a_base_q;
    a_addr_d    = a_addr_q;
    b_ptr_d     = b_ptr_q;
    in_flight_d = in_flight_q;
    issue_s     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.matrices_loaded) begin
          k_lim_d  = bus.K;
          k_d      = '0;
          i_d      = '0;
          j_d      = '0;
          a_base_d = '0;
          a_addr_d = '0;
          b_ptr_d  = '0;
          state_d  = (bus.K == '0) ? DONE : COMPUTE;
        end else begin
          state_d = IDLE;
        end
      end
      COMPUTE: begin
        // A new element needs a free fifo slot beyond those already promised.
        if (!first_s || (bus.fifo_capacity > in_flight_q)) begin
          issue_s = 1'b1;
          if (last_s) begin
            k_d = '0;
            if (j_q == JW'(N - 1)) begin
              j_d      = '0;
              b_ptr_d  = '0;
              a_base_d = a_base_q + AW'(k_lim_q);
              a_addr_d = a_base_q + AW'(k_lim_q);
              i_d      = i_q + IW'(1);
              state_d  = (i_q == IW'(M - 1)) ? DRAIN : COMPUTE;
            end else begin
              j_d      = j_q + JW'(1);
              b_ptr_d  = BW'(j_q) + BW'(1);
              a_addr_d = a_base_q;
            end
          end else begin
            k_d      = k_q + K_BITS'(1);
            b_ptr_d  = b_ptr_q + BW'(N);
            a_addr_d = a_addr_q + AW'(1);
          end
        end else begin
          issue_s = 1'b0;
        end
      end
      DRAIN: begin
        if ((in_flight_q == '0) && !busy_rd_s && !busy_wr_s) state_d = DONE;
        else state_d = DRAIN;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    case ({issue_s & last_s, wr_s})
      2'b10:   in_flight_d = in_flight_q + CW'(1);
      2'b01:   in_flight_d = in_flight_q - CW'(1);
      default: in_flight_d = in_flight_q;
    endcase
  end

  // State, counters and the finish pulse register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      k_lim_q     <= '0;
      k_q         <= '0;
      i_q         <= '0;
      j_q         <= '0;
      a_base_q    <= '0;
      a_addr_q    <= '0;
      b_ptr_q     <= '0;
      in_flight_q <= '0;
      fin_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_lim_q     <= k_lim_d;
      k_q         <= k_d;
      i_q         <= i_d;
      j_q         <= j_d;
      a_base_q    <= a_base_d;
      a_addr_q    <= a_addr_d;
      b_ptr_q     <= b_ptr_d;
      in_flight_q <= in_flight_d;
      fin_q       <= (state_d == DONE);
    end
  end

  mmm_delay_line #(.LAT(RD_LAT), .WIDTH(2)) u_rd_dly (
    .clk    (clk),
    .rst    (reset),
    .d_i    ({issue_s, issue_s & first_s}),
    .q_o    ({vld_s, clr_s}),
    .busy_o (busy_rd_s)
  );

  mmm_delay_line #(.LAT(RD_LAT + MAC_LAT), .WIDTH(1)) u_wr_dly (
    .clk    (clk),
    .rst    (reset),
    .d_i    (issue_s & last_s),
    .q_o    (wr_s),
    .busy_o (busy_wr_s)
  );

  assign bus.A_read_addr      = a_addr_q;
  assign bus.B_read_addr      = b_ptr_q;
  assign bus.valid_input      = vld_s;
  assign bus.clear_acc        = clr_s;
  assign bus.fifo_wr_en       = wr_s;
  assign bus.compute_finished = fin_q;

endmodule

// File: tb/tb_mmm_ctrl.sv
// Scoreboard bench for mmm_ctrl: expected read beats are queued at job start,
// a negedge monitor pops and compares them as valid_input / fifo_wr_en appear.
module tb_mmm_ctrl;
  import mmm_pkg::*;

  localparam int M = 7, N = 9, MAXK = 8, DEPTH = 9, RD_LAT = 1, MAC_LAT = 2;
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct {
    int a;
    int b;
    int clr;
    int last;
  } beat_t;

  logic clk = 1'b0;
  logic reset = 1'b0;

  mmm_if #(.M(M), .N(N), .MAXK(MAXK), .DEPTH(DEPTH)) bus ();

  mmm_ctrl #(.M(M), .N(N), .MAXK(MAXK), .DEPTH(DEPTH),
             .RD_LAT(RD_LAT), .MAC_LAT(MAC_LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  beat_t exp_q[$];
  int    wr_q[$];
  int    errors = 0, checks = 0;
  int    writes = 0, valids = 0, fins = 0;
  int    first_v = 0, last_v = 0, first_w = 0, last_w = 0;
  int    job_start = 0, job_k = 0, exp_writes = 0;
  int    lat_chk = 1, bp_mode = 0, drain_req = 0, cap = DEPTH;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor + fifo_out occupancy model.
  initial begin : monitor
    int    prev_a, prev_b, pend;
    beat_t bt;
    prev_a = 0; prev_b = 0; pend = 0;
    bus.fifo_capacity = CW'(DEPTH);
    forever begin
      @(negedge clk);
      if (reset) begin
        pend = 0; cap = DEPTH; prev_a = 0; prev_b = 0;
      end else begin
        if (bp_mode != 0) cap = cap - pend + drain_req;
        else cap = DEPTH;
        drain_req = 0;
        if (bus.valid_input) begin
          if (valids == 0) first_v = cyc;
          last_v = cyc;
          valids++;
          if (exp_q.size() == 0) chk("unexpected valid_input", 1, 0);
          else begin
            bt = exp_q.pop_front();
            chk("A_read_addr", prev_a, bt.a);
            chk("B_read_addr", prev_b, bt.b);
            chk("clear_acc", int'(bus.clear_acc), bt.clr);
            if (bt.last != 0) wr_q.push_back(cyc + MAC_LAT);
          end
        end else if (bus.clear_acc) chk("clear_acc without valid_input", 1, 0);
        if (bus.fifo_wr_en) begin
          if (writes == 0 && lat_chk != 0)
            chk("first write latency", cyc, job_start + job_k + RD_LAT + MAC_LAT);
          if (writes == 0) first_w = cyc;
          last_w = cyc;
          writes++;
          if (wr_q.size() == 0) chk("unexpected fifo_wr_en", 1, 0);
          else chk("fifo_wr_en cycle", cyc, wr_q.pop_front());
          if (bp_mode != 0) chk("write into full fifo", int'(cap > 0), 1);
        end
        pend = (bp_mode != 0) ? int'(bus.fifo_wr_en) : 0;
        if (bus.compute_finished) begin
          fins++;
          chk("writes at compute_finished", writes, exp_writes);
          chk("beats left at compute_finished", exp_q.size(), 0);
          if (job_k == 0) chk("K=0 finish cycle", cyc, job_start + 1);
        end
        prev_a = int'(bus.A_read_addr);
        prev_b = int'(bus.B_read_addr);
      end
      bus.fifo_capacity = CW'(cap);
    end
  end

  task automatic start_job(input int k);
    beat_t bt;
    exp_q.delete();
    wr_q.delete();
    for (int i = 0; i < M; i++)
      for (int j = 0; j < N; j++)
        for (int kk = 0; kk < k; kk++) begin
          bt.a = i * k + kk;
          bt.b = kk * N + j;
          bt.clr = (kk == 0) ? 1 : 0;
          bt.last = (kk == k - 1) ? 1 : 0;
          exp_q.push_back(bt);
        end
    writes = 0; valids = 0; fins = 0;
    job_k = k;
    exp_writes = (k > 0) ? M * N : 0;
    @(negedge clk);
    job_start = cyc;
    bus.K = 4'(k);
    bus.matrices_loaded = 1'b1;
  endtask

  task automatic wait_fin(input int budget);
    int seen;
    seen = 0;
    for (int t = 0; t < budget; t++) begin
      @(negedge clk);
      if (bus.compute_finished) begin
        seen = 1;
        break;
      end
    end
    bus.matrices_loaded = 1'b0;
    chk("compute_finished seen", seen, 1);
    repeat (5) @(negedge clk);
    chk("compute_finished pulse count", fins, 1);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, " A_read_addr"}, int'(bus.A_read_addr), 0);
    chk({tag, " B_read_addr"}, int'(bus.B_read_addr), 0);
    chk({tag, " valid_input"}, int'(bus.valid_input), 0);
    chk({tag, " clear_acc"}, int'(bus.clear_acc), 0);
    chk({tag, " fifo_wr_en"}, int'(bus.fifo_wr_en), 0);
    chk({tag, " compute_finished"}, int'(bus.compute_finished), 0);
  endtask

  // Directed test sequence.
  initial begin : stim
    int t;
    bus.matrices_loaded = 1'b0;
    bus.K = 4'd0;
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // K=3: address walk and clear_acc placement
    start_job(3);
    wait_fin(3000);
    chk("K=3 valid beats", valids, M * N * 3);
    chk("K=3 issue span", last_v - first_v + 1, M * N * 3);

    // K=8 full size, no bubbles
    start_job(8);
    wait_fin(3000);
    chk("K=8 valid beats", valids, M * N * 8);
    chk("K=8 issue span", last_v - first_v + 1, M * N * 8);
    chk("K=8 writes", writes, M * N);

    // K=1: writes on consecutive cycles
    start_job(1);
    wait_fin(3000);
    chk("K=1 valid beats", valids, M * N);
    chk("K=1 write span", last_w - first_w + 1, M * N);

    // K=0: no activity, immediate finish
    start_job(0);
    wait_fin(50);
    chk("K=0 valid beats", valids, 0);
    chk("K=0 writes", writes, 0);

    // Backpressure: fifo never drained
    lat_chk = 0;
    bp_mode = 1;
    start_job(8);
    for (t = 0; t < 2000 && writes < DEPTH; t++) @(negedge clk);
    chk("bp reached 9 writes in budget", int'(t < 2000), 1);
    repeat (30) @(negedge clk);
    chk("bp writes while full", writes, DEPTH);
    chk("bp beats while full", valids, DEPTH * 8);
    drain_req = 3;
    repeat (60) @(negedge clk);
    chk("bp writes after drain 3", writes, DEPTH + 3);
    chk("bp beats after drain 3", valids, (DEPTH + 3) * 8);
    bp_mode = 0;
    wait_fin(3000);
    chk("bp total writes", writes, M * N);
    lat_chk = 1;

    // Reset in the middle of element 20
    start_job(8);
    for (t = 0; t < 2000 && valids < 20 * 8 + 3; t++) @(negedge clk);
    chk("reached element 20 in budget", int'(t < 2000), 1);
    @(negedge clk);
    reset = 1'b1;
    bus.matrices_loaded = 1'b0;
    #1;
    check_outputs_zero("mid-run reset");
    exp_q.delete();
    wr_q.delete();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    start_job(8);
    wait_fin(3000);
    chk("after reset valid beats", valids, M * N * 8);
    chk("after reset writes", writes, M * N);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mmm_ctrl.md
Name: mmm_ctrl

Overview:
- Sequencing FSM for the matrix-multiply datapath. It waits for input_mems to report both matrices loaded, then walks every output element C[i][j] over k=0..K-1.
- For each step it drives the A/B read addresses, aligns clear_acc/valid_input with the read data into mac_pipe, and issues one fifo_out write per finished element under a free-slot credit check.
- It pulses compute_finished back to input_mems when the last element has been written.

Parameters:
- M, 7: rows of A and C.
- N, 9: columns of B and C.
- MAXK, 8: maximum inner dimension K.
- DEPTH, N: fifo_out depth in entries.
- RD_LAT, 1: input_mems read latency in cycles, address to data.
- MAC_LAT, 2: cycles from valid_input/data at mac_pipe to the updated accumulator at out.
- localparam K_BITS = $clog2(MAXK+1), AW = $clog2(M*MAXK), BW = $clog2(MAXK*N), CW = $clog2(DEPTH+1).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- matrices_loaded  in  1  from input_mems; level, A and B are valid.
- K  in  K_BITS  inner dimension; valid while matrices_loaded is high.
- compute_finished  out  1  one-cycle pulse to input_mems.
- A_read_addr  out  AW  address of A[i][k] = i*K+k.
- B_read_addr  out  BW  address of B[k][j] = k*N+j.
- clear_acc  out  1  to mac_pipe; with valid_input, acc = product.
- valid_input  out  1  to mac_pipe; in0/in1 hold a valid product pair.
- fifo_wr_en  out  1  to fifo_out; mac_pipe out is a finished C element.
- fifo_capacity  in  CW  free entries in fifo_out.

Behaviour:
- Reset (async, active-high):
  - state=IDLE; counters i, j, k, a_base, b_ptr, in_flight = 0.
  - Delay lines cleared.
  - All outputs 0.
- IDLE:
  - On matrices_loaded=1, latch K into k_lim.
  - If K=0, go to DONE: no reads, no writes.
  - Otherwise go to COMPUTE with i=j=k=0, a_base=0, b_ptr=0.
- COMPUTE, one issue per cycle; "issue" means driving the addresses and a 1 into the issue delay line:
  - A_read_addr = a_base+k. B_read_addr = b_ptr.
  - Issue with k=0 only if fifo_capacity > in_flight. Otherwise stall: addresses held, no issue, counters frozen.
  - Issues with k>0 are never stalled.
  - Issue with k=0 marks first=1. Issue with k=k_lim-1 marks last=1. Both are set when k_lim=1.
  - On last: in_flight++, k=0, b_ptr=j+1.
    - If j=N-1: j=0, b_ptr=0, a_base+=k_lim, i++.
    - If i=M-1 and j=N-1: go to DRAIN.
  - Else: k++, b_ptr+=N.
- Pipeline alignment:
  - valid_input and clear_acc = issue and first, delayed RD_LAT cycles.
  - fifo_wr_en = issue and last, delayed RD_LAT+MAC_LAT cycles.
  - in_flight-- on each fifo_wr_en.
  - in_flight++ and -- in the same cycle leaves it unchanged.
- DRAIN: wait until in_flight=0 and the delay lines are empty, then go to DONE.
- DONE:
  - compute_finished=1 for exactly one cycle, then go to IDLE.
  - input_mems drops matrices_loaded on that edge, so no re-trigger.
- Throughput: with no stalls, M*N*K issue cycles with no bubbles between elements. First fifo_wr_en comes K-1+RD_LAT+MAC_LAT cycles after the first issue.
- Credit: fifo_capacity only decreases through this block's writes. With the gate capacity > in_flight, fifo_wr_en never hits a full FIFO, so no elements are lost.
- matrices_loaded is ignored outside IDLE. K is sampled only in IDLE.
- Width rule: a_base max (M-1)*MAXK+MAXK-1 fits AW. b_ptr max (MAXK-1)*N+N-1 fits BW. in_flight is CW bits.
- Reset mid-operation: everything returns to the reset state immediately and any pending writes are discarded. input_mems/fifo_out share the same reset.

Decomposition:
- Package mmm_pkg holds:
  - state enum {IDLE, COMPUTE, DRAIN, DONE};
  - default M/N/MAXK;
  - width helper functions.
- One sub-module, mmm_delay_line (parameter LAT, WIDTH): shift register with async reset, used for the RD_LAT and RD_LAT+MAC_LAT alignment paths.

Test Plan:
- M=2,N=2,K=3, fifo always free:
  - A addrs 0,1,2,0,1,2,3,4,5,3,4,5.
  - B addrs 0,2,4,1,3,5,0,2,4,1,3,5.
  - clear_acc at valid_input beats 1,4,7,10.
  - Four fifo_wr_en; first 2+1+2=5 cycles after the first issue.
- M=7,N=9,K=8, defaults, capacity ≥9:
  - 504 consecutive issue cycles and 63 writes.
  - compute_finished once, after the 63rd write.
- K=1:
  - clear_acc=valid_input on every beat.
  - fifo_wr_en on 63 consecutive cycles.
- Backpressure, DEPTH=9, fifo never drained:
  - Exactly 9 writes, then issues stop with no valid_input.
  - Drain 3 entries: exactly 3 more elements are issued.
  - Full drain leads to 63 total writes, none lost.
- K=0:
  - No valid_input, no fifo_wr_en.
  - compute_finished pulses 1 cycle after leaving IDLE.
- Reset asserted mid-COMPUTE, element 20:
  - All outputs 0 asynchronously, state IDLE.
  - Reload with K=8: the full 63-element result is correct and compute_finished pulses once.
